// File: rtl/rx_frame_module.sv
// rx_frame_module: UART receive framer; detects the start edge, enables the baud
// generator and samples start/data/parity/stop on its mid-bit strobe.
module rx_frame_module #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pin,
    input  logic       bps_clk,
    output logic       bps_start,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t     state, state_next;
    logic       rx_s1, rx_s2, rx_s3;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] shift_reg, shift_next, data_word, rx_data_next;
    logic       par_bit, par_next, par_bad, valid_next, ferr_next, perr_next;

    // Data bits arrive LSB first into the MSB, so a short word sits in the top bits.
    assign data_word = shift_reg >> (8 - DATA_BITS);
    assign par_bad   = (PARITY_EN != 0) && ((^data_word ^ par_bit) != 1'(PARITY_ODD));
    assign rx_busy   = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            bps_start  <= 1'b0;
        end else begin
            rx_s1      <= rx_pin;
            rx_s2      <= rx_s1;
            rx_s3      <= rx_s2;
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            par_bit    <= par_next;
            rx_data    <= rx_data_next;
            rx_valid   <= valid_next;
            frame_err  <= ferr_next;
            parity_err <= perr_next;
            bps_start  <= state_next != IDLE;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        par_next     = par_bit;
        rx_data_next = rx_data;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        perr_next    = 1'b0;
        case (state)
            IDLE: if (rx_s3 & ~rx_s2) state_next = START;
            START: if (bps_clk) begin
                state_next   = rx_s2 ? IDLE : DATA;
                bit_cnt_next = '0;
            end
            DATA: if (bps_clk) begin
                shift_next   = {rx_s2, shift_reg[7:1]};
                bit_cnt_next = bit_cnt + 3'd1;
                if (bit_cnt == 3'(DATA_BITS - 1)) state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (bps_clk) begin
                par_next   = rx_s2;
                state_next = STOP;
            end
            STOP: if (bps_clk) begin
                state_next   = IDLE;
                ferr_next    = ~rx_s2;
                perr_next    = rx_s2 & par_bad;
                valid_next   = rx_s2 & ~par_bad;
                rx_data_next = (rx_s2 & ~par_bad) ? data_word : rx_data;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rx_frame_module.sv
// tb_rx_frame_module: directed frames into an 8N1 and an 8E1 framer, each fed by a
// shortened-period model of the baud generator (first strobe at HALF, then every BIT).
module tb_rx_frame_module;
    localparam int BIT  = 32;
    localparam int HALF = 16;

    logic       clk = 1'b0, reset = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       bclk_a, bclk_b, bs_a, bs_b, val_a, val_b, fe_a, fe_b, pe_a, pe_b, busy_a, busy_b;
    logic [7:0] data_a, data_b;
    int         cnt_a = 0, cnt_b = 0, cyc = 0;
    int         total = 0, bad = 0;
    int         rises_a = 0, nval_a = 0, nfe_a = 0, npe_a = 0, t_rise_a = 0, t_val_a = 0, t_prev_a = 0;
    int         rises_b = 0, nval_b = 0, nfe_b = 0, npe_b = 0, t_rise_b = 0, t_val_b = 0;
    int         d_last_a = 0, d_prev_a = 0;
    logic       bs_a_q = 1'b0, bs_b_q = 1'b0;

    rx_frame_module u_a (.clk(clk), .reset(reset), .rx_pin(rx_a), .bps_clk(bclk_a), .bps_start(bs_a),
        .rx_data(data_a), .rx_valid(val_a), .frame_err(fe_a), .parity_err(pe_a), .rx_busy(busy_a));
    rx_frame_module #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (.clk(clk), .reset(reset), .rx_pin(rx_b),
        .bps_clk(bclk_b), .bps_start(bs_b), .rx_data(data_b), .rx_valid(val_b), .frame_err(fe_b),
        .parity_err(pe_b), .rx_busy(busy_b));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        cnt_a <= (!reset || !bs_a) ? 0 : (cnt_a == BIT - 1 ? 0 : cnt_a + 1);
        cnt_b <= (!reset || !bs_b) ? 0 : (cnt_b == BIT - 1 ? 0 : cnt_b + 1);
    end
    assign bclk_a = bs_a && cnt_a == HALF - 1;
    assign bclk_b = bs_b && cnt_b == HALF - 1;

    always @(negedge clk) begin
        if (bs_a && !bs_a_q) begin rises_a++; t_rise_a = cyc; end
        if (bs_b && !bs_b_q) begin rises_b++; t_rise_b = cyc; end
        bs_a_q = bs_a;
        bs_b_q = bs_b;
        if (val_a) begin nval_a++; t_prev_a = t_val_a; t_val_a = cyc; d_prev_a = d_last_a; d_last_a = int'(data_a); end
        if (val_b) begin nval_b++; t_val_b = cyc; end
        if (fe_a) nfe_a++;
        if (fe_b) nfe_b++;
        if (pe_a) npe_a++;
        if (pe_b) npe_b++;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else rx_a = v;
    endtask

    task automatic hold(input bit sel, input logic v, input int n);
        drive(sel, v);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the line at the stop-bit level so a low stop can continue as a break.
    task automatic send(input bit sel, input logic [7:0] d, input bit has_par, input bit par, input bit stop);
        hold(sel, 1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(sel, d[i], BIT);
        if (has_par) hold(sel, par, BIT);
        hold(sel, stop, BIT);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_bps_start", int'(bs_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_data", int'(data_a), 0);
        check("rst_valid", int'(val_a), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        send(0, 8'hA5, 0, 0, 1);
        check("a5_valid_cnt", nval_a, 1);
        check("a5_data", int'(data_a), 'hA5);
        check("a5_errs", nfe_a + npe_a, 0);
        check("a5_latency", t_val_a - t_rise_a, HALF + 9 * BIT);

        hold(0, 1'b0, 8);
        hold(0, 1'b1, 2 * BIT);
        check("glitch_rise", rises_a, 2);
        check("glitch_idle", int'(bs_a) + int'(busy_a), 0);
        check("glitch_pulses", nval_a * 16 + nfe_a * 4 + npe_a, 16);

        send(0, 8'h3C, 0, 0, 0);
        hold(0, 1'b0, 3 * BIT);
        check("ferr_cnt", nfe_a, 1);
        check("ferr_no_valid", nval_a, 1);
        check("ferr_data_kept", int'(data_a), 'hA5);
        check("break_no_restart", rises_a, 3);
        check("break_idle", int'(busy_a), 0);
        hold(0, 1'b1, BIT);

        send(0, 8'h55, 0, 0, 1);
        send(0, 8'hAA, 0, 0, 1);
        check("b2b_valid_cnt", nval_a, 3);
        check("b2b_first", d_prev_a, 'h55);
        check("b2b_second", int'(data_a), 'hAA);
        check("b2b_gap", t_val_a - t_prev_a, 10 * BIT);

        send(1, 8'h0F, 1, 1, 1);
        check("par_err_cnt", npe_b, 1);
        check("par_no_valid", nval_b, 0);
        check("par_data_kept", int'(data_b), 0);
        hold(1, 1'b1, BIT);
        send(1, 8'h0F, 1, 0, 1);
        check("par_ok_valid", nval_b, 1);
        check("par_ok_data", int'(data_b), 'h0F);
        check("par_ok_latency", t_val_b - t_rise_b, HALF + 10 * BIT);
        check("par_ferr", nfe_b, 0);

        hold(0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(0, i == 0 ? 1'b1 : 1'b0, BIT);
        hold(0, 1'b1, BIT / 2);
        check("mid_busy_before", int'(busy_a), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_bps", int'(bs_a), 0);
        check("mid_rst_busy", int'(busy_a), 0);
        check("mid_rst_data", int'(data_a), 0);
        check("mid_rst_pulses", int'(val_a) + int'(fe_a) + int'(pe_a), 0);
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (BIT) @(negedge clk);
        check("mid_no_pulse", nval_a * 16 + nfe_a * 4 + npe_a, 3 * 16 + 1 * 4);
        send(0, 8'h81, 0, 0, 1);
        check("post_rst_valid", nval_a, 4);
        check("post_rst_data", int'(data_a), 'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
